// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the control unit's memory port. It is a
//   word-addressed RAM with programmable read wait states. The shared DATA bus
//   is driven only while a read is being presented.
//
// Ports
//   CLK    in     1           clock, all state changes on posedge
//   RST    in     1           synchronous reset, active-low
//   ADDR   in     ADDR_WIDTH  word address (low MEM_ADDR_BITS decoded)
//   READ   in     1           read request (level)
//   WRITE  in     1           write request (level)
//   DATA   inout  DATA_WIDTH  write data in / read data out
//   READY  out    1           read data valid or write committed
//   BUSY   out    1           read wait or write commit in progress
//
// State table
//   state       | meaning
//   S_IDLE      | no command in progress, decode READ/WRITE
//   S_RD_WAIT   | read accepted, counting down wait states
//   S_RD_DRIVE  | read data registered and driven while READ held
//   S_WR_COMMIT | write data latched, array updated on the next edge
//   S_WR_HOLD   | write committed, waiting for WRITE to drop or move
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int    DATA_WIDTH    = 32,
    parameter int    ADDR_WIDTH    = 26,
    parameter int    MEM_ADDR_BITS = 16,
    parameter int    RD_LATENCY    = 2,
    parameter string INIT_FILE     = ""
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  READ,
    input  logic                  WRITE,
    inout  wire  [DATA_WIDTH-1:0] DATA,
    output logic                  READY,
    output logic                  BUSY
);

    localparam int         DEPTH    = 2 ** MEM_ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_DRIVE,
        S_WR_COMMIT,
        S_WR_HOLD
    } state_t;

    state_t                     state;
    logic [3:0]                 cnt;
    logic [MEM_ADDR_BITS-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic [DATA_WIDTH-1:0]      mem [0:DEPTH-1];

    logic                       cmd_rd;
    logic                       cmd_wr;
    logic [MEM_ADDR_BITS-1:0]   addr_in;
    logic                       addr_same;
    logic                       start_rd;
    logic                       start_wr;
    logic [DATA_WIDTH-1:0]      rd_launch;
    logic                       unused_addr_hi;

    // Identity compares so that X/Z on either request line decodes as NOP.
    assign cmd_rd    = (READ === 1'b1) && (WRITE === 1'b0);
    assign cmd_wr    = (READ === 1'b0) && (WRITE === 1'b1);

    // Upper address bits are deliberately ignored; the array aliases.
    assign addr_in        = ADDR[MEM_ADDR_BITS-1:0];
    assign unused_addr_hi = ^ADDR[ADDR_WIDTH-1:MEM_ADDR_BITS];
    assign addr_same      = (addr_in == addr_q);

    // A single-cycle read launched on the commit edge of a write to the same
    // word must see the new data, not the pre-commit array contents.
    assign rd_launch = ((state == S_WR_COMMIT) && (addr_q == addr_in)) ? wdata_q : mem[addr_in];

    // Which edges behave like a fresh decode from IDLE.
    always_comb begin
        start_rd = 1'b0;
        start_wr = 1'b0;
        case (state)
            S_IDLE: begin
                start_rd = cmd_rd;
                start_wr = cmd_wr;
            end
            S_RD_WAIT, S_RD_DRIVE: begin
                start_rd = cmd_rd && !addr_same;
                start_wr = cmd_wr;
            end
            S_WR_COMMIT: begin
                start_rd = cmd_rd;
            end
            S_WR_HOLD: begin
                start_rd = cmd_rd;
                start_wr = cmd_wr && !addr_same;
            end
            default: begin
                start_rd = 1'b0;
                start_wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            READY <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            // Status flags follow the state register by one cycle, so READY
            // rises RD_LATENCY cycles after a read is accepted.
            READY <= (state == S_RD_DRIVE) || (state == S_WR_HOLD);
            BUSY  <= (state == S_RD_WAIT)  || (state == S_WR_COMMIT);

            if (start_rd) begin
                addr_q <= addr_in;
                if (RD_LATENCY == 1) begin
                    rd_data <= rd_launch;
                    state   <= S_RD_DRIVE;
                end else begin
                    cnt   <= CNT_LOAD;
                    state <= S_RD_WAIT;
                end
            end else if (start_wr) begin
                addr_q  <= addr_in;
                wdata_q <= DATA;
                state   <= S_WR_COMMIT;
            end else begin
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_RD_WAIT: begin
                        if (!cmd_rd) begin
                            state <= S_IDLE;
                        end else if (cnt == 4'd1) begin
                            rd_data <= mem[addr_q];
                            state   <= S_RD_DRIVE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RD_DRIVE: begin
                        if (!cmd_rd) state <= S_IDLE;
                    end
                    S_WR_COMMIT: begin
                        state <= cmd_wr ? S_WR_HOLD : S_IDLE;
                    end
                    S_WR_HOLD: begin
                        if (!cmd_wr) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The array is never reset; reset on the commit edge suppresses the write.
    always_ff @(posedge CLK) begin
        if (RST && (state == S_WR_COMMIT)) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign DATA = ((state == S_RD_DRIVE) && (READ === 1'b1) && (WRITE === 1'b0))
                  ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int          RD_LAT   = 2;
    localparam int          WR_LAT   = 2;
    localparam logic [31:0] UNDRIVEN = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST;
    logic [25:0] ADDR;
    logic        READ;
    logic        WRITE;
    tri1  [31:0] DATA;
    logic        READY;
    logic        BUSY;

    logic        tb_drv;
    logic [31:0] tb_wd;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word store keyed by the decoded address.
    logic [31:0] ref_mem [logic [15:0]];

    assign DATA = tb_drv ? tb_wd : 'z;

    mem_responder #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (26),
        .MEM_ADDR_BITS(16),
        .RD_LATENCY   (RD_LAT),
        .INIT_FILE    ("")
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .ADDR (ADDR),
        .READ (READ),
        .WRITE(WRITE),
        .DATA (DATA),
        .READY(READY),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bus(input logic rd, input logic wr, input logic [25:0] addr, input logic [31:0] data);
        READ   = rd;
        WRITE  = wr;
        ADDR   = addr;
        tb_wd  = data;
        tb_drv = wr && !rd;
    endtask

    task automatic idle(input int n);
        set_bus(1'b0, 1'b0, ADDR, 32'h0);
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == UNDRIVEN) w = 32'h0;
        return w;
    endfunction

    // One complete transaction: accept edge, wait states, then `hold` extra
    // cycles with the command still asserted.
    task automatic txn(input bit is_wr, input logic [25:0] addr, input logic [31:0] data,
                       input int hold, input string tag);
        int          lat;
        logic [15:0] a;
        logic [31:0] exp;
        a   = addr[15:0];
        lat = is_wr ? WR_LAT : RD_LAT;
        exp = is_wr ? 32'h0 : ref_mem[a];
        set_bus(!is_wr, is_wr, addr, data);
        step();
        if (is_wr) ref_mem[a] = data;
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k < lat) begin
                check({tag, "_wait_ready"}, 32'(READY), 32'd0);
                check({tag, "_wait_busy"}, 32'(BUSY), 32'd1);
            end
        end
        check({tag, "_ready"}, 32'(READY), 32'd1);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        if (!is_wr) check({tag, "_data"}, DATA, exp);
        for (int h = 0; h < hold; h++) begin
            if (is_wr) tb_wd = rand_word();
            step();
            check({tag, "_hold_ready"}, 32'(READY), 32'd1);
            if (!is_wr) check({tag, "_hold_data"}, DATA, exp);
        end
    endtask

    initial begin
        bit          is_wr;
        bit          prev_wr;
        logic [15:0] prev_a;
        logic [25:0] a;
        int          gap;

        // Reset with a read request pending: nothing may be driven.
        RST = 1'b0;
        set_bus(1'b1, 1'b0, 26'h10, 32'h0);
        step();
        step();
        check("reset_ready", 32'(READY), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_data_z", DATA, UNDRIVEN);
        RST = 1'b1;
        idle(2);
        check("idle_ready", 32'(READY), 32'd0);

        // Basic write then read with two wait states.
        txn(1'b1, 26'h10, 32'hDEAD_BEEF, 0, "t1_wr");
        idle(2);
        txn(1'b0, 26'h10, 32'h0, 2, "t1_rd");
        idle(2);

        // READ and WRITE together is a NOP: no write, no drive.
        txn(1'b1, 26'h20, 32'h1111_2222, 0, "t2_pre");
        idle(2);
        set_bus(1'b1, 1'b1, 26'h20, 32'h9999_9999);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_ready", 32'(READY), 32'd0);
            check("t2_busy", 32'(BUSY), 32'd0);
            check("t2_data_z", DATA, UNDRIVEN);
        end
        idle(1);
        txn(1'b0, 26'h20, 32'h0, 0, "t2_rd");
        idle(2);

        // Upper address bits alias onto the same word.
        txn(1'b1, 26'h001_0005, 32'h1234_5678, 0, "t3_wr");
        idle(2);
        txn(1'b0, 26'h000_0005, 32'h0, 0, "t3_rd");
        idle(2);

        // Reset on the commit edge discards the write.
        txn(1'b1, 26'h30, 32'h0BAD_F00D, 0, "t4_pre");
        idle(2);
        set_bus(1'b0, 1'b1, 26'h30, 32'hA5A5_A5A5);
        step();
        RST = 1'b0;
        step();
        check("t4_rst_ready", 32'(READY), 32'd0);
        check("t4_rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b1;
        idle(1);
        check("t4_post_ready", 32'(READY), 32'd0);
        set_bus(1'b1, 1'b0, 26'h30, 32'h0);
        #1;
        check("t4_post_data_z", DATA, UNDRIVEN);
        txn(1'b0, 26'h30, 32'h0, 0, "t4_rd");
        idle(2);

        // Address change during the wait restarts the full latency.
        txn(1'b1, 26'h40, 32'h4040_4040, 0, "t5_wr40");
        txn(1'b1, 26'h41, 32'h4141_4141, 0, "t5_wr41");
        idle(2);
        set_bus(1'b1, 1'b0, 26'h40, 32'h0);
        step();
        txn(1'b0, 26'h41, 32'h0, 1, "t5_rd");
        idle(2);

        // Randomized traffic against the model, including direct command
        // switches, address moves under a held command and data wiggle
        // while a write is held.
        for (int i = 0; i < 8; i++) begin
            txn(1'b1, {10'($urandom), 16'h0100 + 16'(i)}, rand_word(), 0, "prefill");
        end
        prev_wr = 1'b1;
        prev_a  = 16'h0107;
        for (int n = 0; n < 40; n++) begin
            is_wr = 1'($urandom_range(0, 1));
            a     = {10'($urandom), 16'h0100 + 16'($urandom_range(0, 7))};
            gap   = int'($urandom_range(0, 2));
            if (gap == 0 && is_wr == prev_wr && a[15:0] == prev_a) gap = 1;
            if (gap != 0) idle(gap);
            txn(is_wr, a, rand_word(), int'($urandom_range(0, 3)), is_wr ? "rnd_wr" : "rnd_rd");
            prev_wr = is_wr;
            prev_a  = a[15:0];
        end
        idle(2);
        check("final_ready", 32'(READY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
